core_div_seq: RTL and testbench

CORE_DIV_SEQ -- requirements
Module: core_div_seq

---
 rtl/core_div_seq.sv | 195 +++++++++++++++++++
 tb/tb_core_div_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and their word forms.
// Retires BPC quotient bits per cycle; divide-by-zero and signed overflow finish without iterating.
module core_div_seq #(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_isword,
  input  logic [XLEN-1:0] i_div_srcA,
  input  logic [XLEN-1:0] i_div_srcB,
  input  logic            i_div_kill,
  output logic            o_div_valid,
  input  logic            i_div_result_ready,
  output logic [XLEN-1:0] o_div_result,
  output logic            o_div_busy
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN / BPC) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;

  logic [1:0]       ctrl_p0;
  logic             isword_p0;
  logic             neg_a_p0;
  logic             neg_b_p0;
  logic [XLEN-1:0]  dvsr_p0;

  logic [XLEN-1:0]  rem_p1;
  logic [XLEN-1:0]  quo_p1;
  logic [XLEN-1:0]  res_p1;

  logic [XLEN-1:0]  rem_nx;
  logic [XLEN-1:0]  quo_nx;
  logic [XLEN+1:0]  trial;

  logic                   accept;
  logic                   is_signed;
  logic                   is_rem;
  logic signed [XLEN-1:0] a_ext;
  logic signed [XLEN-1:0] b_ext;
  logic                   sgn_a;
  logic                   sgn_b;
  logic [XLEN-1:0]        mag_a;
  logic [XLEN-1:0]        mag_b;
  logic [XLEN-1:0]        quo_init;
  logic [XLEN-1:0]        min_w;
  logic                   div_zero;
  logic                   ovf;
  logic [XLEN-1:0]        special_res;
  logic [XLEN-1:0]        final_res;

  // Widen a W-bit operand to XLEN, sign- or zero-extending word operands.
  function automatic logic [XLEN-1:0] fn_opnd(input logic [XLEN-1:0] v, input logic w,
                                              input logic s);
    if (w) return {{HALF{s & v[HALF-1]}}, v[HALF-1:0]};
    return v;
  endfunction

  function automatic logic [XLEN-1:0] fn_wext(input logic [XLEN-1:0] v, input logic w);
    if (w) return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
    return v;
  endfunction

  function automatic logic [XLEN-1:0] fn_wmask(input logic [XLEN-1:0] v, input logic w);
    if (w) return {{HALF{1'b0}}, v[HALF-1:0]};
    return v;
  endfunction

  function automatic logic [XLEN-1:0] fn_fixup(input logic [XLEN-1:0] q, input logic [XLEN-1:0] r,
                                               input logic rem_op, input logic na, input logic nb,
                                               input logic w);
    logic [XLEN-1:0] v;
    if (rem_op) v = na ? -r : r;
    else        v = (na ^ nb) ? -q : q;
    return fn_wext(v, w);
  endfunction

  assign accept    = i_div_valid && (state == S_IDLE) && !i_div_kill;
  assign is_signed = !i_div_control[0];
  assign is_rem    = i_div_control[1];
  assign a_ext     = fn_opnd(i_div_srcA, i_div_isword, is_signed);
  assign b_ext     = fn_opnd(i_div_srcB, i_div_isword, is_signed);
  assign sgn_a     = is_signed && a_ext[XLEN-1];
  assign sgn_b     = is_signed && b_ext[XLEN-1];
  assign mag_a     = fn_wmask(sgn_a ? -a_ext : a_ext, i_div_isword);
  assign mag_b     = fn_wmask(sgn_b ? -b_ext : b_ext, i_div_isword);
  // Dividend is left-aligned so word and full ops shift out of the same MSB.
  assign quo_init  = i_div_isword ? (mag_a << HALF) : mag_a;
  assign min_w     = i_div_isword ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                                  : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero  = (b_ext == '0);
  assign ovf       = is_signed && (a_ext == min_w) && (b_ext == '1);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = is_rem ? fn_wext(i_div_srcA, i_div_isword) : '1;
    else if (ovf) special_res = is_rem ? '0 : fn_wext(i_div_srcA, i_div_isword);
  end

  always_comb begin
    rem_nx = rem_p1;
    quo_nx = quo_p1;
    trial  = '0;
    for (int i = 0; i < BPC; i++) begin
      trial = {1'b0, rem_nx, quo_nx[XLEN-1]} - {2'b00, dvsr_p0};
      if (!trial[XLEN+1]) begin
        rem_nx = trial[XLEN-1:0];
        quo_nx = {quo_nx[XLEN-2:0], 1'b1};
      end else begin
        rem_nx = {rem_nx[XLEN-2:0], quo_nx[XLEN-1]};
        quo_nx = {quo_nx[XLEN-2:0], 1'b0};
      end
    end
  end

  assign cnt_last  = isword_p0 ? CNT_W'(HALF / BPC - 1) : CNT_W'(XLEN / BPC - 1);
  assign final_res = fn_fixup(fn_wmask(quo_nx, isword_p0), rem_nx, ctrl_p0[1],
                              neg_a_p0, neg_b_p0, isword_p0);

  // Control: FSM, iteration counter, captured op attributes and the result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ctrl_p0   <= '0;
      isword_p0 <= 1'b0;
      neg_a_p0  <= 1'b0;
      neg_b_p0  <= 1'b0;
      res_p1    <= '0;
    end else if (i_div_kill) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_div_valid) begin
            ctrl_p0   <= i_div_control;
            isword_p0 <= i_div_isword;
            neg_a_p0  <= sgn_a;
            neg_b_p0  <= sgn_b;
            cnt       <= '0;
            if (div_zero || ovf) begin
              state  <= S_DONE;
              res_p1 <= special_res;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt == cnt_last) begin
            state  <= S_DONE;
            res_p1 <= final_res;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (i_div_result_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: divisor magnitude, partial remainder and quotient shift register.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      dvsr_p0 <= mag_b;
      rem_p1  <= '0;
      quo_p1  <= quo_init;
    end else if (state == S_CALC) begin
      rem_p1 <= rem_nx;
      quo_p1 <= quo_nx;
    end
  end

  assign o_div_ready  = (state == S_IDLE);
  assign o_div_valid  = (state == S_DONE);
  assign o_div_busy   = (state != S_IDLE);
  assign o_div_result = res_p1;

endmodule

// File: tb/tb_core_div_seq.sv
// Bench for core_div_seq (XLEN=64, BPC=1): directed vectors checked against an arithmetic reference model.
module tb_core_div_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_div_valid = 1'b0;
  logic        o_div_ready;
  logic [1:0]  i_div_control = 2'b00;
  logic        i_div_isword = 1'b0;
  logic [63:0] i_div_srcA = '0;
  logic [63:0] i_div_srcB = '0;
  logic        i_div_kill = 1'b0;
  logic        o_div_valid;
  logic        i_div_result_ready = 1'b0;
  logic [63:0] o_div_result;
  logic        o_div_busy;

  core_div_seq #(.XLEN(64), .BPC(1)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_div_valid        (i_div_valid),
    .o_div_ready        (o_div_ready),
    .i_div_control      (i_div_control),
    .i_div_isword       (i_div_isword),
    .i_div_srcA         (i_div_srcA),
    .i_div_srcB         (i_div_srcB),
    .i_div_kill         (i_div_kill),
    .o_div_valid        (o_div_valid),
    .i_div_result_ready (i_div_result_ready),
    .o_div_result       (o_div_result),
    .o_div_busy         (o_div_busy)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic was_valid = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain language-level division with the special cases spelled out.
  function automatic logic [63:0] model(input logic [1:0] c, input logic w, input logic [63:0] a,
                                        input logic [63:0] b, output int lat);
    logic        rem_op;
    logic        sgn;
    logic [63:0] r;
    logic [31:0] r32;
    longint      sa;
    longint      sb;
    int          wa;
    int          wb;
    logic [31:0] ua;
    logic [31:0] ub;
    rem_op = c[1];
    sgn    = !c[0];
    if (!w) begin
      sa  = a;
      sb  = b;
      lat = 65;
      if (b == 64'd0) begin
        r = rem_op ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        lat = 1;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        r = rem_op ? 64'd0 : a;
        lat = 1;
      end else if (sgn) r = rem_op ? 64'(sa % sb) : 64'(sa / sb);
      else              r = rem_op ? a % b : a / b;
      return r;
    end
    ua  = a[31:0];
    ub  = b[31:0];
    wa  = ua;
    wb  = ub;
    lat = 33;
    if (ub == 32'd0) begin
      r32 = rem_op ? ua : 32'hFFFF_FFFF;
      lat = 1;
    end else if (sgn && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
      r32 = rem_op ? 32'd0 : ua;
      lat = 1;
    end else if (sgn) r32 = rem_op ? 32'(wa % wb) : 32'(wa / wb);
    else              r32 = rem_op ? ua % ub : ua / ub;
    return {{32{r32[31]}}, r32};
  endfunction

  // Compare process: every cycle the result is presented, it must match the model.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_div_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {63'd0, o_div_valid}, 64'd0);
        end else begin
          check("result", o_div_result, exp_q[0].res);
          check("busy_in_done", {63'd0, o_div_busy}, 64'd1);
          if (!was_valid)
            check("latency", 64'(cyc - exp_q[0].acc + 1), 64'(exp_q[0].lat));
        end
      end else if (was_valid && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      was_valid = o_div_valid;
    end else begin
      was_valid = 1'b0;
    end
  end

  task automatic start_op(input logic [1:0] c, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] lit);
    exp_t e;
    int   lat;
    e.res = model(c, w, a, b, lat);
    e.lat = lat;
    check("model_pin", e.res, lit);
    @(negedge i_clk);
    for (int k = 0; k < 200 && !o_div_ready; k++) @(negedge i_clk);
    check("ready_before_accept", {63'd0, o_div_ready}, 64'd1);
    i_div_control = c;
    i_div_isword  = w;
    i_div_srcA    = a;
    i_div_srcB    = b;
    i_div_valid   = 1'b1;
    @(posedge i_clk);
    #1;
    e.acc = cyc;
    exp_q.push_back(e);
    i_div_valid   = 1'b0;
    i_div_control = 2'($urandom);
    i_div_isword  = 1'($urandom);
    i_div_srcA    = {$urandom, $urandom};
    i_div_srcB    = {$urandom, $urandom};
  endtask

  task automatic do_op(input logic [1:0] c, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lit, input int hold);
    start_op(c, w, a, b, lit);
    @(negedge i_clk);
    for (int k = 0; k < 200 && !o_div_valid; k++) @(negedge i_clk);
    check("valid_seen", {63'd0, o_div_valid}, 64'd1);
    repeat (hold) @(negedge i_clk);
    i_div_result_ready = 1'b1;
    @(negedge i_clk);
    i_div_result_ready = 1'b0;
    check("ready_after_handoff", {63'd0, o_div_ready}, 64'd1);
    check("valid_after_handoff", {63'd0, o_div_valid}, 64'd0);
  endtask

  initial begin
    #2;
    check("rst_ready", {63'd0, o_div_ready}, 64'd1);
    check("rst_valid", {63'd0, o_div_valid}, 64'd0);
    check("rst_busy", {63'd0, o_div_busy}, 64'd0);
    check("rst_result", o_div_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    do_op(OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op(OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 0);
    do_op(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
    do_op(OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    do_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 10);
    do_op(OP_DIV,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 0);
    do_op(OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    do_op(OP_DIV,  1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    do_op(OP_REMU, 1'b1, 64'hDEAD_BEEF_0000_0007, 64'hFFFF_FFFF_0000_0000, 64'd7, 2);
    do_op(OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0);
    do_op(OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 0);
    do_op(OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 0);
    do_op(OP_DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op(OP_REMU, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'd1, 0);

    // Kill mid-calculation: the operation must vanish without a result.
    start_op(OP_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333);
    repeat (20) @(negedge i_clk);
    i_div_kill = 1'b1;
    @(posedge i_clk);
    #1;
    i_div_kill = 1'b0;
    exp_q.delete();
    check("kill_ready", {63'd0, o_div_ready}, 64'd1);
    check("kill_busy", {63'd0, o_div_busy}, 64'd0);
    repeat (80) @(negedge i_clk);

    // Kill beats a simultaneous request.
    i_div_valid = 1'b1;
    i_div_kill  = 1'b1;
    i_div_srcA  = 64'd100;
    i_div_srcB  = 64'd7;
    @(posedge i_clk);
    #1;
    i_div_valid = 1'b0;
    i_div_kill  = 1'b0;
    check("kill_blocks_accept", {63'd0, o_div_ready}, 64'd1);
    repeat (5) @(negedge i_clk);
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 0);

    // Reset mid-calculation, then accept on the first edge after release.
    start_op(OP_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333);
    repeat (20) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_ready", {63'd0, o_div_ready}, 64'd1);
    check("midrst_valid", {63'd0, o_div_valid}, 64'd0);
    check("midrst_busy", {63'd0, o_div_busy}, 64'd0);
    check("midrst_result", o_div_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 0);

    repeat (3) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
